// File: rtl/core_inst_pkg.sv
// core_inst_pkg
//   Shared definitions for the PE-core instruction sequencer.
//   - Bit positions of every named field in the 64-bit core inst bus.
//   - IDLE_INST: the quiescent instruction. Both SRAMs are deselected and
//     write-disabled, and every other bit is 0.
//   - state_t: sequencer FSM states.
//   - inst_fields_t / idle_fields(): named-field view of one instruction.
package core_inst_pkg;

  localparam int INST_W = 64;
  localparam int ADDR_W = 11;

  // Field bit positions on the inst bus
  localparam int B_LOAD        = 0;
  localparam int B_EXECUTE     = 1;
  localparam int B_L0_WR       = 2;
  localparam int B_L0_RD       = 3;
  localparam int B_IFIFO_RD    = 4;
  localparam int B_IFIFO_WR    = 5;
  localparam int B_OFIFO_RD    = 6;
  localparam int B_A_XMEM_LSB  = 7;   // [17:7]
  localparam int B_WEN_XMEM    = 18;
  localparam int B_CEN_XMEM    = 19;
  localparam int B_A_PMEM_LSB  = 20;  // [30:20]
  localparam int B_WEN_PMEM    = 31;
  localparam int B_CEN_PMEM    = 32;
  localparam int B_ACC         = 33;
  localparam int B_PASSTHROUGH = 34;
  localparam int B_REN_PMEM    = 35;

  // CEN_pmem, WEN_pmem, CEN_xmem and WEN_xmem high; everything else low
  localparam logic [INST_W-1:0] IDLE_INST = 64'h0000_0001_800C_0000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_W_FETCH    = 3'd1,
    ST_W_LOAD     = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_A_STREAM   = 3'd4,
    ST_DRAIN_WAIT = 3'd5,
    ST_DRAIN_RD   = 3'd6,
    ST_DRAIN_WR   = 3'd7
  } state_t;

  typedef struct packed {
    logic              ren_pmem;
    logic              passthrough;
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_fields_t;

  // Field values that pack to IDLE_INST
  function automatic inst_fields_t idle_fields();
    inst_fields_t f;
    f             = '0;
    f.cen_pmem    = 1'b1;
    f.wen_pmem    = 1'b1;
    f.cen_xmem    = 1'b1;
    f.wen_xmem    = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/core_inst_pack.sv
// core_inst_pack
//   Combinational packing of the named instruction fields onto the 64-bit
//   core inst bus. Bits [63:36] are always 0.
// Ports
//   i_fields  in   inst_fields_t  named field values
//   o_inst    out  64             packed instruction word
module core_inst_pack
  import core_inst_pkg::*;
(
  input  inst_fields_t        i_fields,
  output logic [INST_W-1:0]   o_inst
);

  always_comb begin
    o_inst                                 = '0;
    o_inst[B_LOAD]                         = i_fields.load;
    o_inst[B_EXECUTE]                      = i_fields.execute;
    o_inst[B_L0_WR]                        = i_fields.l0_wr;
    o_inst[B_L0_RD]                        = i_fields.l0_rd;
    o_inst[B_IFIFO_RD]                     = i_fields.ififo_rd;
    o_inst[B_IFIFO_WR]                     = i_fields.ififo_wr;
    o_inst[B_OFIFO_RD]                     = i_fields.ofifo_rd;
    o_inst[B_A_XMEM_LSB +: ADDR_W]         = i_fields.a_xmem;
    o_inst[B_WEN_XMEM]                     = i_fields.wen_xmem;
    o_inst[B_CEN_XMEM]                     = i_fields.cen_xmem;
    o_inst[B_A_PMEM_LSB +: ADDR_W]         = i_fields.a_pmem;
    o_inst[B_WEN_PMEM]                     = i_fields.wen_pmem;
    o_inst[B_CEN_PMEM]                     = i_fields.cen_pmem;
    o_inst[B_ACC]                          = i_fields.acc;
    o_inst[B_PASSTHROUGH]                  = i_fields.passthrough;
    o_inst[B_REN_PMEM]                     = i_fields.ren_pmem;
  end

endmodule

// File: rtl/core_inst_seq.sv
// core_inst_seq
//   Sequencer that drives the PE core instruction bus through one full
//   convolution tile. For each kernel index kij: fetch weights from xmem into
//   L0, load them into the array, let the array settle, stream activations,
//   then drain the OFIFO into PSUM SRAM (accumulating for kij > 0).
// Ports
//   clk          in   1   clock
//   reset        in   1   asynchronous active-high reset (aborts the tile)
//   start        in   1   1-cycle request, honoured only in IDLE
//   ofifo_valid  in   1   core OFIFO holds a full column-aligned row
//   inst         out  64  registered core instruction bus
//   busy         out  1   high whenever the FSM is not in IDLE
//   done         out  1   1-cycle pulse with the final drain write
//   kij          out  4   current kernel index
module core_inst_seq
  import core_inst_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int LEN_KIJ = 9,
  parameter int LEN_NIJ = 36,
  parameter int W_BASE  = 1024,
  parameter int A_BASE  = 0,
  parameter int P_BASE  = 0,
  parameter int SETTLE  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij
);

  // One shared phase counter; 8 bits covers LEN_NIJ+1, col and SETTLE.
  localparam int CNT_W = 8;
  // The array needs at least row+col idle cycles to flush; never settle less.
  localparam int SETTLE_EFF = (SETTLE < row + col) ? (row + col) : SETTLE;

  localparam logic [CNT_W-1:0] C_COL      = CNT_W'(col);
  localparam logic [CNT_W-1:0] C_COL_LAST = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] C_SET_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [CNT_W-1:0] C_NIJ      = CNT_W'(LEN_NIJ);
  localparam logic [CNT_W-1:0] C_NIJ_END  = CNT_W'(LEN_NIJ + 1);
  localparam logic [CNT_W-1:0] C_P_LAST   = CNT_W'(LEN_NIJ - 1);
  localparam logic [3:0]       C_KIJ_LAST = 4'(LEN_KIJ - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   r_p;
  logic [CNT_W-1:0]   w_p_nxt;
  logic [3:0]         r_kij;
  logic [3:0]         w_kij_nxt;
  logic               w_done_nxt;
  logic [INST_W-1:0]  r_inst;
  logic               r_busy;
  logic               r_done;
  inst_fields_t       w_fields;
  logic [INST_W-1:0]  w_inst;

  // Address arithmetic wraps at 11 bits by construction.
  logic [ADDR_W-1:0]  w_w_addr;
  logic [ADDR_W-1:0]  w_a_addr;
  logic [ADDR_W-1:0]  w_p_addr;

  assign w_w_addr = ADDR_W'(W_BASE) + ADDR_W'(r_kij) * ADDR_W'(col) + ADDR_W'(r_cnt);
  assign w_a_addr = ADDR_W'(A_BASE) + ADDR_W'(r_cnt);
  assign w_p_addr = ADDR_W'(P_BASE) + ADDR_W'(r_p);

  // Next-state, counter updates and instruction fields for the current state
  always_comb begin
    w_next_state = r_state;
    w_cnt_nxt    = r_cnt;
    w_p_nxt      = r_p;
    w_kij_nxt    = r_kij;
    w_done_nxt   = 1'b0;
    w_fields     = idle_fields();

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_W_FETCH;
          w_kij_nxt    = 4'd0;
          w_cnt_nxt    = '0;
          w_p_nxt      = '0;
        end else begin
          w_next_state = ST_IDLE;
        end
      end

      // SRAM data lags its address by a cycle, so the L0 write trails the
      // fetch by one and the phase runs col+1 cycles.
      ST_W_FETCH: begin
        if (r_cnt < C_COL) begin
          w_fields.cen_xmem = 1'b0;
          w_fields.a_xmem   = w_w_addr;
        end else begin
          w_fields.cen_xmem = 1'b1;
        end
        w_fields.l0_wr = (r_cnt >= 8'd1);
        if (r_cnt == C_COL) begin
          w_next_state = ST_W_LOAD;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt    = r_cnt + 8'd1;
        end
      end

      ST_W_LOAD: begin
        w_fields.l0_rd = 1'b1;
        w_fields.load  = 1'b1;
        if (r_cnt == C_COL_LAST) begin
          w_next_state = ST_SETTLE;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt    = r_cnt + 8'd1;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == C_SET_LAST) begin
          w_next_state = ST_A_STREAM;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt    = r_cnt + 8'd1;
        end
      end

      // Three-stage pipeline: fetch at n, L0 write at n+1, execute at n+2.
      ST_A_STREAM: begin
        if (r_cnt < C_NIJ) begin
          w_fields.cen_xmem = 1'b0;
          w_fields.a_xmem   = w_a_addr;
        end else begin
          w_fields.cen_xmem = 1'b1;
        end
        w_fields.l0_wr   = (r_cnt >= 8'd1) && (r_cnt <= C_NIJ);
        w_fields.l0_rd   = (r_cnt >= 8'd2);
        w_fields.execute = (r_cnt >= 8'd2);
        if (r_cnt == C_NIJ_END) begin
          w_next_state = ST_DRAIN_WAIT;
          w_cnt_nxt    = '0;
          w_p_nxt      = '0;
        end else begin
          w_cnt_nxt    = r_cnt + 8'd1;
        end
      end

      ST_DRAIN_WAIT: begin
        if (ofifo_valid) begin
          w_next_state = ST_DRAIN_RD;
        end else begin
          w_next_state = ST_DRAIN_WAIT;
        end
      end

      ST_DRAIN_RD: begin
        w_fields.cen_pmem = 1'b0;
        w_fields.ren_pmem = 1'b1;
        w_fields.a_pmem   = w_p_addr;
        w_next_state      = ST_DRAIN_WR;
      end

      // kij 0 overwrites stale PSUM; later kernel positions accumulate.
      ST_DRAIN_WR: begin
        w_fields.cen_pmem = 1'b0;
        w_fields.wen_pmem = 1'b0;
        w_fields.a_pmem   = w_p_addr;
        w_fields.ofifo_rd = 1'b1;
        w_fields.acc      = (r_kij != 4'd0);
        if (r_p < C_P_LAST) begin
          w_p_nxt      = r_p + 8'd1;
          w_next_state = ST_DRAIN_WAIT;
        end else if (r_kij < C_KIJ_LAST) begin
          w_kij_nxt    = r_kij + 4'd1;
          w_cnt_nxt    = '0;
          w_next_state = ST_W_FETCH;
        end else begin
          w_done_nxt   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  core_inst_pack u_pack (
    .i_fields (w_fields),
    .o_inst   (w_inst)
  );

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_kij   <= 4'd0;
      r_inst  <= IDLE_INST;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_nxt;
      r_p     <= w_p_nxt;
      r_kij   <= w_kij_nxt;
      r_inst  <= w_inst;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;
  assign kij  = r_kij;

endmodule
